branch_predictor: RTL and testbench
===================================

# branch_predictor

Dynamic branch predictor with a fetch-side lookup port and a memory-stage resolve/update port. In F it predicts conditional branches from a direct-mapped table of 2-bit saturating counters plus a tagged target buffer (BHT/BTB); the prediction travels down the pipe as `guess`. In M it consumes the executeâmemory register outputs (`pc`, `is_branch`, `is_jalr`, `branch_taken`, `guess`, `jb_addr`), trains the tables, raises a pipeline flush with a redirect PC on misprediction, and keeps branch statistics.

## Interface
- `ENTRIES`, default 64: BHT/BTB depth; power of two, at least 4.
- `IDX_W`, default $clog2(ENTRIES): index width. Index is `pc[IDX_W+1:2]`; tag is `pc[31:IDX_W+2]`.
- `clk`  in  1: clock; all state updates on the rising edge.
- `rst`  in  1: reset. One clock; reset is asynchronous and active-high.
- `f_pc`  in  32: fetch PC to predict.
- `f_guess`  out  1: predicted taken.
- `f_target`  out  32: predicted target; 0 when `f_guess`=0.
- `m_pc`  in  32: PC of the instruction in M.
- `m_is_branch`  in  1: conditional branch in M. Already 0 for flushed slots.
- `m_is_jalr`  in  1: JALR in M. Already 0 for flushed slots.
- `m_taken`  in  1: resolved branch outcome.
- `m_guess`  in  1: prediction made in F for this instruction.
- `m_jb_addr`  in  32: resolved branch or JALR target.
- `mispredict`  out  1: flush F/D/E and redirect fetch.
- `redirect_pc`  out  32: next fetch PC when `mispredict`=1, otherwise 0.
- `br_cnt`  out  32: conditional branches retired from M.
- `miss_cnt`  out  32: mispredict events.

## Operation
- State:
  - `cnt[ENTRIES]`: 2-bit counters. 00 is strong not-taken, 01 weak NT, 10 weak T, 11 strong T.
  - `valid[ENTRIES]`, `tag[ENTRIES]`, `target[ENTRIES]` (32 bits each).
  - `br_cnt`, `miss_cnt`.
- Lookup (combinational):
  - hit = `valid[i]` and `tag[i]` equals the tag of `f_pc`.
  - `f_guess` = hit and `cnt[i][1]`.
  - `f_target` = `target[i]` when `f_guess`=1, else 0.
- Resolve (combinational on the M inputs), conditional branches (`m_is_branch`=1):
  - `m_taken` and not `m_guess`: mispredict; redirect = `m_jb_addr`.
  - not `m_taken` and `m_guess`: mispredict; redirect = `m_pc`+4, with 32-bit wrap.
  - `m_taken` and `m_guess`: no mispredict. Branch targets are PC-relative, so a tag hit guarantees a correct target.
- Resolve, JALR (`m_is_jalr`=1): never predicted. Always mispredict; redirect = `m_jb_addr`.
- If `m_is_branch` and `m_is_jalr` are both 1, JALR wins.
- Update on the clock edge when `m_is_branch`=1, using index j taken from `m_pc`:
  - `cnt[j]` increments on taken and decrements on not-taken, saturating at 11 and 00.
  - On taken: `valid[j]`=1, `tag[j]` = tag of `m_pc`, `target[j]`=`m_jb_addr`. If the tag differed, `cnt[j]` is loaded with 10 instead of the increment.
  - On not-taken with a tag mismatch: the entry is left untouched.
- JALR never updates the tables.
- Statistics:
  - `br_cnt` increments by 1 for each `m_is_branch` cycle.
  - `miss_cnt` increments by 1 for each `mispredict` cycle.
  - Both wrap from 0xFFFFFFFF to 0.

## Timing
- Lookup has zero latency: `f_guess` and `f_target` are valid in the same cycle as `f_pc`.
- `mispredict` and `redirect_pc` are valid in the same cycle as the M inputs. The M inputs come from registers, so no combinational loop exists. The consumer flushes on the next edge.
- Table writes are visible to lookup from the cycle after the update edge.
- Same-index read and write in one cycle: lookup returns the old value; there is no bypass.
- Reset (asynchronous, any time, including mid-update):
  - every `cnt` = 01; every `valid` = 0; `br_cnt` = 0; `miss_cnt` = 0.
  - `f_guess` = 0, `f_target` = 0, `mispredict` = 0, `redirect_pc` = 0, because every M input is 0 under reset.
  - `tag` and `target` are don't-care while `valid` = 0.
- Aliasing: two PCs with the same index and different tags evict each other; the counter is re-seeded to 10 on each install.

## Structure
- Shared package holds:
  - counter encodings `CNT_SNT`, `CNT_WNT`, `CNT_WT`, `CNT_ST`
  - reset value `CNT_RST` = `CNT_WNT`
  - the PC step constant 4
- One sub-module: `sat_cnt2`, a combinational 2-bit saturating next-state (inputs `cnt` and `taken`; output next `cnt`). It is instantiated once for the M-stage write port.

## Test plan
- Reset, then `f_pc`=0x100: `f_guess`=0, `f_target`=0, `br_cnt`=0.
- M branch with `m_pc`=0x100, taken, `m_guess`=0, `m_jb_addr`=0x180:
  - `mispredict`=1, `redirect_pc`=0x180.
  - Next cycle, `f_pc`=0x100 gives `f_guess`=1, `f_target`=0x180; `miss_cnt`=1.
- Same branch taken twice more, then not-taken with `m_guess`=1:
  - `redirect_pc`=0x104.
  - Counter goes 11 then 10, and `f_guess` stays 1.
- Alias case with `ENTRIES`=64: install 0x100 taken, then resolve 0x200 (same index) taken to 0x240:
  - Lookup of 0x100 misses.
  - Lookup of 0x200 gives `f_target`=0x240.
- JALR at `m_pc`=0x300 with `m_jb_addr`=0x40: `mispredict`=1, `redirect_pc`=0x40, tables unchanged, `br_cnt` unchanged.
- Assert `rst` mid-stream after 5 branches: all outputs read 0 immediately, without waiting for a clock edge, and a previously hot PC no longer predicts.

Source files
------------

// File: rtl/branch_predictor_pkg.sv
// Shared constants for the branch predictor: 2-bit counter encodings and the PC step.
package branch_predictor_pkg;

    localparam logic [1:0]  CNT_SNT = 2'b00;
    localparam logic [1:0]  CNT_WNT = 2'b01;
    localparam logic [1:0]  CNT_WT  = 2'b10;
    localparam logic [1:0]  CNT_ST  = 2'b11;
    localparam logic [1:0]  CNT_RST = CNT_WNT;

    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/branch_predictor_sat_cnt2.sv
// Combinational next-state for a 2-bit saturating taken/not-taken counter.
module sat_cnt2
    import branch_predictor_pkg::*;
(
    input  logic [1:0] cnt_i,
    input  logic       taken_i,
    output logic [1:0] cnt_o
);

    always_comb begin
        cnt_o = cnt_i;
        if (taken_i) begin
            if (cnt_i != CNT_ST) cnt_o = cnt_i + 2'd1;
        end else begin
            if (cnt_i != CNT_SNT) cnt_o = cnt_i - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BHT/BTB predictor: zero-latency fetch lookup, M-stage resolve,
// table training and branch/mispredict statistics.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int ENTRIES = 64,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] f_pc,
    output logic        f_guess,
    output logic [31:0] f_target,
    input  logic [31:0] m_pc,
    input  logic        m_is_branch,
    input  logic        m_is_jalr,
    input  logic        m_taken,
    input  logic        m_guess,
    input  logic [31:0] m_jb_addr,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] br_cnt,
    output logic [31:0] miss_cnt
);

    localparam int TAG_W = 32 - IDX_W - 2;

    logic [1:0]       cnt_q    [ENTRIES];
    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [31:0]      br_cnt_q;
    logic [31:0]      miss_cnt_q;

    logic [IDX_W-1:0] f_idx;
    logic [TAG_W-1:0] f_tag;
    logic             f_hit;

    logic [IDX_W-1:0] m_idx;
    logic [TAG_W-1:0] m_tag;
    logic             m_hit;
    logic             upd_en;
    logic [1:0]       cnt_upd;
    logic [1:0]       cnt_d;

    // Fetch lookup reads the registered tables; a same-cycle write is not bypassed.
    assign f_idx    = f_pc[IDX_W+1:2];
    assign f_tag    = f_pc[31:IDX_W+2];
    assign f_hit    = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
    assign f_guess  = f_hit && cnt_q[f_idx][1];
    assign f_target = f_guess ? target_q[f_idx] : 32'd0;

    // JALR is never predicted, so it always redirects and takes priority.
    always_comb begin
        mispredict  = 1'b0;
        redirect_pc = 32'd0;
        if (m_is_jalr) begin
            mispredict  = 1'b1;
            redirect_pc = m_jb_addr;
        end else if (m_is_branch) begin
            if (m_taken && !m_guess) begin
                mispredict  = 1'b1;
                redirect_pc = m_jb_addr;
            end else if (!m_taken && m_guess) begin
                mispredict  = 1'b1;
                redirect_pc = m_pc + PC_STEP;
            end
        end
    end

    assign m_idx  = m_pc[IDX_W+1:2];
    assign m_tag  = m_pc[31:IDX_W+2];
    assign m_hit  = valid_q[m_idx] && (tag_q[m_idx] == m_tag);
    assign upd_en = m_is_branch && !m_is_jalr;

    sat_cnt2 u_sat_cnt2 (
        .cnt_i   (cnt_q[m_idx]),
        .taken_i (m_taken),
        .cnt_o   (cnt_upd)
    );

    // A fresh install (taken on a tag miss) seeds the counter at weak-taken.
    assign cnt_d = m_hit ? cnt_upd : CNT_WT;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '{default: CNT_RST};
            valid_q    <= '0;
            br_cnt_q   <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else begin
            if (upd_en && (m_taken || m_hit)) cnt_q[m_idx] <= cnt_d;
            if (upd_en && m_taken) valid_q[m_idx] <= 1'b1;
            if (m_is_branch) br_cnt_q <= br_cnt_q + 32'd1;
            if (mispredict) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    // Tag and target are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        if (upd_en && m_taken) begin
            tag_q[m_idx]    <= m_tag;
            target_q[m_idx] <= m_jb_addr;
        end
    end

    assign br_cnt   = br_cnt_q;
    assign miss_cnt = miss_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed scenarios plus randomized
// branch/JALR traffic compared against a table-level reference model.
module tb_branch_predictor;

    localparam int N = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] f_pc;
    logic        f_guess;
    logic [31:0] f_target;
    logic [31:0] m_pc;
    logic        m_is_branch;
    logic        m_is_jalr;
    logic        m_taken;
    logic        m_guess;
    logic [31:0] m_jb_addr;
    logic        mispredict;
    logic [31:0] redirect_pc;
    logic [31:0] br_cnt;
    logic [31:0] miss_cnt;

    int checks   = 0;
    int failures = 0;

    // Reference model: per-entry strength 0..3, install flag, owning tag, target.
    int          r_str [N];
    bit          r_vld [N];
    logic [23:0] r_tag [N];
    logic [31:0] r_tgt [N];
    logic [31:0] r_br;
    logic [31:0] r_miss;

    branch_predictor #(.ENTRIES(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .f_pc        (f_pc),
        .f_guess     (f_guess),
        .f_target    (f_target),
        .m_pc        (m_pc),
        .m_is_branch (m_is_branch),
        .m_is_jalr   (m_is_jalr),
        .m_taken     (m_taken),
        .m_guess     (m_guess),
        .m_jb_addr   (m_jb_addr),
        .mispredict  (mispredict),
        .redirect_pc (redirect_pc),
        .br_cnt      (br_cnt),
        .miss_cnt    (miss_cnt)
    );

    always #5 clk = ~clk;

    function automatic int idx_of(input logic [31:0] pc);
        return int'(pc[7:2]);
    endfunction

    function automatic bit model_hit(input logic [31:0] pc);
        int i = idx_of(pc);
        return r_vld[i] && (r_tag[i] == pc[31:8]);
    endfunction

    function automatic bit model_guess(input logic [31:0] pc);
        return model_hit(pc) && (r_str[idx_of(pc)] >= 2);
    endfunction

    function automatic logic [31:0] model_target(input logic [31:0] pc);
        return model_guess(pc) ? r_tgt[idx_of(pc)] : 32'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            r_str[i] = 1;
            r_vld[i] = 1'b0;
        end
        r_br   = 0;
        r_miss = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic zero_m();
        m_pc        = 32'd0;
        m_is_branch = 1'b0;
        m_is_jalr   = 1'b0;
        m_taken     = 1'b0;
        m_guess     = 1'b0;
        m_jb_addr   = 32'd0;
    endtask

    // Drive one M-stage instruction plus a fetch probe, check the combinational
    // outputs, then let the edge happen and advance the model.
    task automatic m_step(input logic [31:0] pc, input bit isb, input bit isj,
                          input bit tk, input bit gs, input logic [31:0] addr,
                          input logic [31:0] fpc);
        bit          e_mis;
        logic [31:0] e_red;
        int          j;
        @(negedge clk);
        m_pc = pc; m_is_branch = isb; m_is_jalr = isj;
        m_taken = tk; m_guess = gs; m_jb_addr = addr; f_pc = fpc;
        #1;
        e_mis = 1'b0;
        e_red = 32'd0;
        if (isj) begin
            e_mis = 1'b1; e_red = addr;
        end else if (isb && tk && !gs) begin
            e_mis = 1'b1; e_red = addr;
        end else if (isb && !tk && gs) begin
            e_mis = 1'b1; e_red = pc + 32'd4;
        end
        chk("mispredict", {31'd0, mispredict}, {31'd0, e_mis});
        chk("redirect_pc", redirect_pc, e_red);
        chk("f_guess", {31'd0, f_guess}, {31'd0, model_guess(fpc)});
        chk("f_target", f_target, model_target(fpc));
        @(posedge clk);
        j = idx_of(pc);
        if (isb && !isj) begin
            if (tk) begin
                r_str[j] = model_hit(pc) ? ((r_str[j] == 3) ? 3 : r_str[j] + 1) : 2;
                r_vld[j] = 1'b1;
                r_tag[j] = pc[31:8];
                r_tgt[j] = addr;
            end else if (model_hit(pc)) begin
                r_str[j] = (r_str[j] == 0) ? 0 : r_str[j] - 1;
            end
        end
        if (isb) r_br = r_br + 32'd1;
        if (e_mis) r_miss = r_miss + 32'd1;
    endtask

    task automatic probe(input logic [31:0] fpc);
        @(negedge clk);
        zero_m();
        f_pc = fpc;
        #1;
        chk("probe_f_guess", {31'd0, f_guess}, {31'd0, model_guess(fpc)});
        chk("probe_f_target", f_target, model_target(fpc));
        chk("br_cnt", br_cnt, r_br);
        chk("miss_cnt", miss_cnt, r_miss);
    endtask

    initial begin
        int          kind;
        logic [31:0] pc;
        logic [31:0] fpc;
        bit          tk;
        bit          gs;

        rst = 1'b1;
        f_pc = 32'h100;
        zero_m();
        model_reset();
        #1;
        chk("rst_f_guess", {31'd0, f_guess}, 32'd0);
        chk("rst_f_target", f_target, 32'd0);
        chk("rst_mispredict", {31'd0, mispredict}, 32'd0);
        chk("rst_br_cnt", br_cnt, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        probe(32'h100);

        // Install on a taken branch that was not predicted.
        m_step(32'h100, 1, 0, 1, 0, 32'h180, 32'h100);
        probe(32'h100);
        chk("installed_guess", {31'd0, f_guess}, 32'd1);
        chk("installed_target", f_target, 32'h180);
        chk("installed_miss_cnt", miss_cnt, 32'd1);

        m_step(32'h100, 1, 0, 1, 1, 32'h180, 32'h100);
        m_step(32'h100, 1, 0, 1, 1, 32'h180, 32'h100);
        m_step(32'h100, 1, 0, 0, 1, 32'h180, 32'h100);
        probe(32'h100);
        chk("after_nt_guess", {31'd0, f_guess}, 32'd1);

        // Same index, different tag: evicts the 0x100 entry.
        m_step(32'h200, 1, 0, 1, 0, 32'h240, 32'h200);
        probe(32'h100);
        chk("alias_evicted", {31'd0, f_guess}, 32'd0);
        probe(32'h200);
        chk("alias_target", f_target, 32'h240);

        m_step(32'h300, 0, 1, 0, 0, 32'h40, 32'h200);
        probe(32'h200);
        probe(32'h300);

        // Fall-through redirect wraps at the top of the address space.
        m_step(32'hFFFF_FFFC, 1, 0, 0, 1, 32'h0, 32'h0);
        probe(32'hFFFF_FFFC);

        for (int n = 0; n < 400; n++) begin
            pc   = {22'd0, 2'(1 + $urandom_range(0, 3)), 6'($urandom_range(0, 7)), 2'b00};
            fpc  = {22'd0, 2'(1 + $urandom_range(0, 3)), 6'($urandom_range(0, 7)), 2'b00};
            kind = $urandom_range(0, 9);
            tk   = 1'($urandom_range(0, 1));
            gs   = ($urandom_range(0, 3) == 0) ? !model_guess(pc) : model_guess(pc);
            if (kind == 0)
                m_step(pc, 0, 1, 0, 0, {$urandom} & 32'hFFFF_FFFC, fpc);
            else if (kind == 1)
                m_step(pc, 0, 0, tk, gs, 32'd0, fpc);
            else
                m_step(pc, 1, 0, tk, gs, {$urandom} & 32'hFFFF_FFFC, fpc);
            if (n % 50 == 49) probe(fpc);
        end

        // Five taken branches on one PC, then an asynchronous reset between edges.
        for (int k = 0; k < 5; k++)
            m_step(32'h1C0, 1, 0, 1, model_guess(32'h1C0), 32'h2000, 32'h1C0);
        probe(32'h1C0);
        chk("hot_before_reset", {31'd0, f_guess}, 32'd1);
        @(negedge clk);
        zero_m();
        f_pc = 32'h1C0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_f_guess", {31'd0, f_guess}, 32'd0);
        chk("async_f_target", f_target, 32'd0);
        chk("async_mispredict", {31'd0, mispredict}, 32'd0);
        chk("async_redirect_pc", redirect_pc, 32'd0);
        chk("async_br_cnt", br_cnt, 32'd0);
        chk("async_miss_cnt", miss_cnt, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        probe(32'h1C0);
        chk("cold_after_reset", {31'd0, f_guess}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
